// File: rtl/reg8_ser_pkg.sv
// Shared types and constants for the reg8_serializer slice.
package reg8_ser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } ser_state_e;

   localparam int DEFAULT_WIDTH = 8;

   // Bit-counter width; a single bit is the floor so WIDTH=2 still works.
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/reg8_serializer_piso.sv
// Parallel-in serial-out shift register with a fixed output tap.
// MSB_FIRST=1 taps bit WIDTH-1 and shifts left; otherwise taps bit 0 and
// shifts right. Vacated positions fill with zero.
module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             shift_i,
   output logic             bit_o
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   // Load has priority over shift; otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
         else           sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
   end

   // Register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) sr_q <= '0;
      else       sr_q <= sr_d;
   end

   assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/reg8_serializer.sv
// Byte serializer: valid/ready word load, valid/ready bit stream out.
// Build option: REG8_SER_PARITY_EN appends an even-parity bit to each frame.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | waiting for a word, in_ready=1, no serial output
//   ST_SHIFT  | presenting data bits, count_q = bits already sent
//   ST_PARITY | presenting the parity bit (parity build only)
module reg8_serializer
   import reg8_ser_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             sdo,
   output logic             sdo_valid,
   input  logic             sdo_ready,
   output logic             sdo_last,
   output logic             busy
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef REG8_SER_PARITY_EN
   localparam ser_state_e ST_AFTER_DATA = ST_PARITY;
   localparam bit         PAR_EN        = 1'b1;
`else
   localparam ser_state_e ST_AFTER_DATA = ST_IDLE;
   localparam bit         PAR_EN        = 1'b0;
`endif

   ser_state_e    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          load;
   logic          shift_en;
   logic          cnt_at_last;
   logic          tap_bit;
   logic          par_bit;

   assign load        = in_valid && (state_q == ST_IDLE);
   assign shift_en    = sdo_ready && (state_q == ST_SHIFT);
   assign cnt_at_last = (count_q == CNT_LAST);

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (load),
      .data_i  (data_in),
      .shift_i (shift_en),
      .bit_o   (tap_bit)
   );

`ifdef REG8_SER_PARITY_EN
   logic parity_q, parity_d;

   // Capture even parity of the word at load time.
   always_comb begin
      parity_d = parity_q;
      if (load) parity_d = ^data_in;
   end

   // Parity register.
   always_ff @(posedge CLK) begin
      if (RST) parity_q <= 1'b0;
      else     parity_q <= parity_d;
   end

   assign par_bit = parity_q;
`else
   assign par_bit = 1'b0;
`endif

   // Bit counter: cleared at load, advances per accepted data bit, wraps to 0 on the last.
   always_comb begin
      count_d = count_q;
      if (load)          count_d = '0;
      else if (shift_en) count_d = cnt_at_last ? '0 : count_q + 1'b1;
   end

   // State and counter registers; RST wins over any same-edge load.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (in_valid) state_d = ST_SHIFT;
         ST_SHIFT:  if (sdo_ready && cnt_at_last) state_d = ST_AFTER_DATA;
         ST_PARITY: if (sdo_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state only; nothing combinational from inputs.
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      sdo_valid = 1'b1;
      sdo       = 1'b0;
      sdo_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready  = 1'b1;
            busy      = 1'b0;
            sdo_valid = 1'b0;
         end
         ST_SHIFT: begin
            sdo      = tap_bit;
            sdo_last = cnt_at_last && !PAR_EN;
         end
         ST_PARITY: begin
            sdo      = par_bit;
            sdo_last = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            busy      = 1'b0;
            sdo_valid = 1'b0;
         end
      endcase
   end

endmodule
